// File: rtl/apb_master_pkg.sv
// Shared definitions for the APB requester: FSM state encoding, default
// bus widths and the default ACCESS-phase wait limit.
package apb_master_pkg;

  localparam int APB_ADDR_W  = 8;
  localparam int APB_DATA_W  = 8;
  localparam int APB_TIMEOUT = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

  // Counter width able to hold the value TIMEOUT itself.
  function automatic int wait_cnt_w(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/apb_master_if.sv
// Command/response port and APB bus of the requester, bundled together.
// master: the requester's view. slave: the APB completer's view of the bus.
interface apb_master_if import apb_master_pkg::*; #(
  parameter int ADDR_W = APB_ADDR_W,
  parameter int DATA_W = APB_DATA_W
) ();

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;

  logic              P_sel;
  logic              P_enable;
  logic              P_write;
  logic [ADDR_W-1:0] P_addr;
  logic [DATA_W-1:0] P_wdata;
  logic [DATA_W-1:0] P_rdata;
  logic              P_ready;
  logic              P_slverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  P_rdata, P_ready, P_slverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output P_sel, P_enable, P_write, P_addr, P_wdata
  );

  modport slave (
    input  P_sel, P_enable, P_write, P_addr, P_wdata,
    output P_rdata, P_ready, P_slverr
  );

endinterface

// File: rtl/apb_wait_timer.sv
// Counts ACCESS cycles spent waiting for P_ready. 'expired' flags the cycle
// in which one more wait would reach TIMEOUT, so the FSM can abort on it.
module apb_wait_timer import apb_master_pkg::*; #(
  parameter int TIMEOUT = APB_TIMEOUT
) (
  input  logic P_clk,
  input  logic P_reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int              CNT_W = wait_cnt_w(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  // Wait counter: cleared in SETUP, advanced on every un-ready ACCESS cycle.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge P_clk or negedge P_reset_n) begin
    if (!P_reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/apb_master.sv
// APB requester: one command at a time, SETUP -> ACCESS, bounded wait for
// P_ready, single-cycle response pulse carrying read data and error status.
module apb_master import apb_master_pkg::*; #(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = APB_TIMEOUT
) (
  input  logic         P_clk,
  input  logic         P_reset_n,
  apb_master_if.master bus
);

  apb_state_e        state_q, state_d;
  logic              handshake;
  logic              done_ok, done_to;
  logic              timer_clear, timer_en, timer_expired;

  logic              write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_err_q;
  logic              rsp_timeout_q;

  // Ready is also held low while reset is asserted so every output reads 0.
  assign bus.cmd_ready = (state_q == ST_IDLE) && P_reset_n;
  assign handshake     = bus.cmd_valid && bus.cmd_ready;

  assign timer_clear = (state_q == ST_SETUP);
  assign timer_en    = (state_q == ST_ACCESS) && !bus.P_ready;

  apb_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .P_clk     (P_clk),
    .P_reset_n (P_reset_n),
    .clear     (timer_clear),
    .enable    (timer_en),
    .expired   (timer_expired)
  );

  // State register.
  always_ff @(posedge P_clk or negedge P_reset_n) begin
    if (!P_reset_n) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  // Next state and completion decode; P_ready beats the timeout in the same cycle.
  always_comb begin
    // NOTE: defaults first so no path through the case leaves a variable unassigned (no latch).
    state_d = state_q;
    done_ok = 1'b0;
    done_to = 1'b0;
    unique case (state_q)
      ST_IDLE:   if (handshake) state_d = ST_SETUP;
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (bus.P_ready) begin
          done_ok = 1'b1;
          state_d = ST_IDLE;
        end else if (timer_expired) begin
          done_to = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  // Capture the accepted command; held stable for the whole transfer and after it.
  always_ff @(posedge P_clk or negedge P_reset_n) begin
    if (!P_reset_n) begin
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (handshake) begin
      write_q <= bus.cmd_write;
      addr_q  <= bus.cmd_addr;
      wdata_q <= bus.cmd_wdata;
    end
  end

  // Response: valid pulses for one cycle, payload holds until the next completion.
  always_ff @(posedge P_clk or negedge P_reset_n) begin
    if (!P_reset_n) begin
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      rsp_valid_q <= done_ok || done_to;
      if (done_ok) begin
        rsp_rdata_q   <= write_q ? '0 : bus.P_rdata;
        rsp_err_q     <= bus.P_slverr;
        rsp_timeout_q <= 1'b0;
      end else if (done_to) begin
        rsp_rdata_q   <= '0;
        rsp_err_q     <= 1'b1;
        rsp_timeout_q <= 1'b1;
      end
    end
  end

  assign bus.P_sel       = (state_q != ST_IDLE);
  assign bus.P_enable    = (state_q == ST_ACCESS);
  assign bus.P_write     = write_q;
  assign bus.P_addr      = addr_q;
  assign bus.P_wdata     = wdata_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_timeout_q;

endmodule
